ws2812_driver: RTL and testbench
================================

# ws2812_driver

Serialises a 16-pixel, 24-bit-per-pixel framebuffer onto a single-wire WS2812 LED data line. Sits downstream of the timer logic: it reads the 384-bit `framebuf` that the timer writes and generates the NRZ high/low-pulse waveform plus the latch gap. A frame is taken as an atomic snapshot at start, so framebuffer updates mid-frame never tear.

## Interface
Parameters:
- `NUM_LEDS`, 16: pixels per frame; the framebuffer width is `NUM_LEDS*24`.
- `T0H`, 4: high time of a '0' bit, in clk cycles.
- `T1H`, 8: high time of a '1' bit, in clk cycles.
- `T_BIT`, 15: total bit period, in clk cycles.
- `T_RESET`, 600: low latch time after the last bit, in clk cycles.

Ports:
- `clk`  in  1  system clock; the only clock.
- `nrst`  in  1  asynchronous, active-low reset.
- `framebuf`  in  `NUM_LEDS*24`  pixel data; pixel p occupies `[24p+23:24p]`. Within a pixel, G is `[7:0]`, R is `[15:8]`, B is `[23:16]`.
- `start`  in  1  frame request; sampled only in IDLE.
- `dout`  out  1  WS2812 data line.
- `busy`  out  1  frame in progress, including the latch gap.
- `frame_done`  out  1  single-cycle pulse in the final cycle of a frame.

## Operation
- States: IDLE, SEND, LATCH.
- IDLE:
  - `dout`=0, `busy`=0.
  - When `start`=1 at a rising edge: copy `framebuf` into the shadow register, clear the bit index, and enter SEND.
- SEND:
  - Bits are sent pixel 0 first.
  - Within each pixel the order is G[7]..G[0], then R[7]..R[0], then B[7]..B[0], each byte MSB first.
  - For the shadow pixel p, the bit at transmit position k (k=0..23) is `shadow[24p + 8*(k/8) + 7 - (k%8)]`.
  - Per bit: `dout`=1 for T0H or T1H cycles (bit value 0 or 1), then `dout`=0 for the remainder of T_BIT.
  - After bit `NUM_LEDS*24-1` completes, enter LATCH.
- LATCH:
  - `dout`=0 for T_RESET cycles.
  - `frame_done`=1 in the last LATCH cycle, then return to IDLE.
- `start` is ignored while `busy`=1; there is no queuing.
- `framebuf` changes during a frame have no effect on the frame in progress.
- Counter widths:
  - phase counter is `$clog2(max(T_BIT,T_RESET))` bits;
  - bit index is `$clog2(NUM_LEDS*24)` bits.
  - No counter wraps except by explicit reload.
- Elaboration-time checks: 1 ≤ T0H < T1H < T_BIT, and T_RESET ≥ 1. Violating either is a fatal error.

## Timing
- Reset values:
  - `dout`=0, `busy`=0, `frame_done`=0;
  - state IDLE, counters 0, shadow register 0.
- Reset mid-frame: all outputs go to their reset values immediately (asynchronously), and the partial frame is abandoned.
- Latency: with `start` sampled at edge n, `busy`=1 and `dout`=1 from the cycle after edge n. This is the first bit's high phase.
- Frame length: `busy` is high for exactly `NUM_LEDS*24*T_BIT + T_RESET` cycles. The default is 384×15+600 = 6360.
- `frame_done` coincides with the last `busy`=1 cycle; `busy`=0 in the following cycle.
- Back-to-back: with `start` held high, IDLE lasts exactly one cycle between frames. The frame period is 6361 cycles at defaults.
- A `start` pulse landing on the `frame_done` cycle is dropped.
- Bit boundaries are glitch-free: `dout` is registered, and each bit's rising edge follows the previous bit's low phase with no extra cycle.

## Structure
- Shared package `ws2812_pkg`:
  - state enum (IDLE/SEND/LATCH);
  - localparams `BITS_PER_PIXEL`=24, and byte offsets G=0, R=8, B=16;
  - default timing constants.
- Sub-module `ws2812_bit_timer`:
  - inputs: `bit_val`, `go`;
  - outputs: the pulse on `dout`, and `bit_done` in the last cycle of T_BIT;
  - it owns the phase counter.
- The top level owns the FSM, the shadow register, bit selection and the LATCH counter.

## Test plan
- Reset then idle: hold `start`=0 for 1000 cycles -> `dout`=0, `busy`=0 and `frame_done`=0 throughout.
- All-zero frame: `framebuf`=0 and a 1-cycle `start` pulse ->
  - 384 pulses, each high 4 cycles then low 11;
  - then 600 low cycles;
  - `frame_done` pulse at cycle 6360, then `busy`=0.
- Bit order: pixel 0 = 24'hFF_00_81 (B=FF, R=00, G=81), all other pixels 0 ->
  - decoded first 24 bits = 1000_0001 0000_0000 1111_1111 (high times 8/4 cycles);
  - every remaining bit is a '0'.
- Snapshot and ignore: start a frame, change `framebuf` to all-ones and pulse `start` at cycle 100 -> the decoded frame equals the original data, and only one `frame_done` occurs.
- Back-to-back: hold `start`=1 for 3 frames -> `frame_done` at cycles 6360, 12721 and 19082, with one `busy`=0 cycle between frames.
- Async reset mid-frame: assert `nrst`=0 during the high phase of bit 50 ->
  - `dout` and `busy` go to 0 in the same cycle, without waiting for a clock edge;
  - after release, the next `start` produces a complete correct frame.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared types, constants and helpers for the WS2812 framebuffer serialiser.
package ws2812_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    LATCH = 2'd2
  } state_e;

  localparam int BITS_PER_PIXEL = 24;
  localparam int G_OFFSET       = 0;
  localparam int R_OFFSET       = 8;
  localparam int B_OFFSET       = 16;

  localparam int DEF_NUM_LEDS = 16;
  localparam int DEF_T0H      = 4;
  localparam int DEF_T1H      = 8;
  localparam int DEF_T_BIT    = 15;
  localparam int DEF_T_RESET  = 600;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Transmit slot k walks G, R, B in turn, each byte MSB first.
  function automatic logic [4:0] tx_index(input logic [4:0] k);
    logic [4:0] base;
    case (k[4:3])
      2'd0:    base = 5'(G_OFFSET);
      2'd1:    base = 5'(R_OFFSET);
      default: base = 5'(B_OFFSET);
    endcase
    return base + 5'd7 - {2'b00, k[2:0]};
  endfunction

endpackage

// File: rtl/ws2812_if.sv
// Framebuffer/handshake bundle between the timer logic and the WS2812 driver.
interface ws2812_if
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS
);

  logic [NUM_LEDS*BITS_PER_PIXEL-1:0] framebuf;
  logic                               start;
  logic                               dout;
  logic                               busy;
  logic                               frame_done;

  modport master (
    output framebuf,
    output start,
    input  dout,
    input  busy,
    input  frame_done
  );

  modport slave (
    input  framebuf,
    input  start,
    output dout,
    output busy,
    output frame_done
  );

endinterface

// File: rtl/ws2812_bit_timer.sv
// Produces one NRZ bit on a registered line: high for T0H/T1H cycles, low for the rest of T_BIT.
module ws2812_bit_timer #(
  parameter int T0H     = 4,
  parameter int T1H     = 8,
  parameter int T_BIT   = 15,
  parameter int PHASE_W = 10
) (
  input  logic clk,
  input  logic nrst,
  input  logic bit_val,
  input  logic go,
  output logic dout,
  output logic bit_done
);

  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [PHASE_W-1:0] phase_nxt;
  logic [PHASE_W-1:0] high_len;
  logic               active_q, active_d;
  logic               dout_q, dout_d;

  assign bit_done = active_q && (phase_q == PHASE_W'(T_BIT - 1));
  assign dout     = dout_q;

  // A go in the last cycle of a bit restarts immediately, so consecutive bits abut.
  always_comb begin
    high_len  = bit_val ? PHASE_W'(T1H) : PHASE_W'(T0H);
    phase_nxt = phase_q + 1'b1;
    phase_d   = phase_q;
    active_d  = active_q;
    dout_d    = dout_q;
    if (go) begin
      phase_d  = '0;
      active_d = 1'b1;
      dout_d   = 1'b1;
    end else if (active_q) begin
      if (bit_done) begin
        phase_d  = '0;
        active_d = 1'b0;
        dout_d   = 1'b0;
      end else begin
        phase_d = phase_nxt;
        dout_d  = (phase_nxt < high_len);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      phase_q  <= '0;
      active_q <= 1'b0;
      dout_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      active_q <= active_d;
      dout_q   <= dout_d;
    end
  end

endmodule

// File: rtl/ws2812_driver.sv
// Serialises a snapshot of the framebuffer onto the WS2812 data line, then holds the latch gap.
module ws2812_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_LEDS = DEF_NUM_LEDS,
  parameter int T0H      = DEF_T0H,
  parameter int T1H      = DEF_T1H,
  parameter int T_BIT    = DEF_T_BIT,
  parameter int T_RESET  = DEF_T_RESET
) (
  input  logic     clk,
  input  logic     nrst,
  ws2812_if.slave  bus
);

  localparam int FB_W    = NUM_LEDS * BITS_PER_PIXEL;
  localparam int PHASE_W = $clog2(max2(T_BIT, T_RESET));
  localparam int BIDX_W  = $clog2(FB_W);

  if (!(T0H >= 1 && T0H < T1H && T1H < T_BIT)) begin : g_bad_bit_timing
    $fatal(1, "ws2812_driver: need 1 <= T0H < T1H < T_BIT");
  end
  if (T_RESET < 1) begin : g_bad_reset_timing
    $fatal(1, "ws2812_driver: need T_RESET >= 1");
  end

  state_e                    state_q, state_d;
  logic [FB_W-1:0]           shadow_q, shadow_d;
  logic [BIDX_W-1:0]         bit_idx_q, bit_idx_d;
  logic [4:0]                pix_bit_q, pix_bit_d;
  logic [PHASE_W-1:0]        latch_cnt_q, latch_cnt_d;
  logic                      busy_q, busy_d;
  logic                      frame_done_q, frame_done_d;

  logic                      go;
  logic                      bit_done;
  logic                      cur_bit;
  logic                      line;
  logic [BITS_PER_PIXEL-1:0] cur_pixel;

  // The shadow shifts down one pixel at a time, so the current pixel is always the low slice.
  assign cur_pixel = shadow_q[BITS_PER_PIXEL-1:0];
  assign cur_bit   = cur_pixel[tx_index(pix_bit_q)];

  ws2812_bit_timer #(
    .T0H     (T0H),
    .T1H     (T1H),
    .T_BIT   (T_BIT),
    .PHASE_W (PHASE_W)
  ) u_bit_timer (
    .clk      (clk),
    .nrst     (nrst),
    .bit_val  (cur_bit),
    .go       (go),
    .dout     (line),
    .bit_done (bit_done)
  );

  always_comb begin
    state_d      = state_q;
    shadow_d     = shadow_q;
    bit_idx_d    = bit_idx_q;
    pix_bit_d    = pix_bit_q;
    latch_cnt_d  = latch_cnt_q;
    busy_d       = busy_q;
    frame_done_d = 1'b0;
    go           = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          shadow_d  = bus.framebuf;
          bit_idx_d = '0;
          pix_bit_d = '0;
          busy_d    = 1'b1;
          go        = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (bit_done) begin
          if (bit_idx_q == BIDX_W'(FB_W - 1)) begin
            latch_cnt_d  = '0;
            frame_done_d = (T_RESET == 1);
            state_d      = LATCH;
          end else begin
            go        = 1'b1;
            bit_idx_d = bit_idx_q + 1'b1;
            if (pix_bit_q == 5'(BITS_PER_PIXEL - 1)) begin
              pix_bit_d = '0;
              shadow_d  = shadow_q >> BITS_PER_PIXEL;
            end else begin
              pix_bit_d = pix_bit_q + 1'b1;
            end
          end
        end
      end
      LATCH: begin
        // frame_done is registered, so it is raised on entry to the final latch cycle.
        if (latch_cnt_q == PHASE_W'(T_RESET - 1)) begin
          latch_cnt_d = '0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end else begin
          latch_cnt_d  = latch_cnt_q + 1'b1;
          frame_done_d = (latch_cnt_d == PHASE_W'(T_RESET - 1));
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      shadow_q     <= '0;
      bit_idx_q    <= '0;
      pix_bit_q    <= '0;
      latch_cnt_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shadow_q     <= shadow_d;
      bit_idx_q    <= bit_idx_d;
      pix_bit_q    <= pix_bit_d;
      latch_cnt_q  <= latch_cnt_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.dout       = line;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_ws2812_driver.sv
// Self-checking bench for ws2812_driver: compares the line waveform against a per-cycle reference model.
module tb_ws2812_driver;

  localparam int NUM_LEDS  = 16;
  localparam int T0H       = 4;
  localparam int T1H       = 8;
  localparam int T_BIT     = 15;
  localparam int T_RESET   = 600;
  localparam int NB        = NUM_LEDS * 24;
  localparam int SEND_CYC  = NB * T_BIT;
  localparam int FRAME_CYC = SEND_CYC + T_RESET;

  logic clk;
  logic nrst;
  int   checks;
  int   errors;
  int   cyc;

  ws2812_if #(.NUM_LEDS(NUM_LEDS)) bus ();

  ws2812_driver #(
    .NUM_LEDS (NUM_LEDS),
    .T0H      (T0H),
    .T1H      (T1H),
    .T_BIT    (T_BIT),
    .T_RESET  (T_RESET)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: pixel p, transmit slot k maps to framebuf[24p + 8*(k/8) + 7 - (k%8)].
  function automatic logic expBit(input logic [NB-1:0] fb, input int b);
    int p;
    int k;
    p = b / 24;
    k = b % 24;
    return fb[24*p + 8*(k/8) + 7 - (k%8)];
  endfunction

  function automatic logic [NB-1:0] randFb();
    logic [NB-1:0] r;
    for (int i = 0; i < NB/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic applyStimulus(input logic [NB-1:0] fb, input logic st);
    bus.framebuf = fb;
    bus.start    = st;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  // Runs one frame from the current negedge; optionally pulses start (with altFb) at cycle pulseAt.
  task automatic runFrame(input logic [NB-1:0] fb, input string tag, input int pulseAt,
                          input logic [NB-1:0] altFb, input bit holdStart, output int doneCyc);
    int   doutErr, busyErr, decErr, doneCount, doneAt, highCnt, firstErr, last, t, b, ph;
    logic expDout, expBusy, decoded;
    doutErr = 0; busyErr = 0; decErr = 0; doneCount = 0; doneAt = -1;
    highCnt = 0; firstErr = -1; doneCyc = -1; b = 0; ph = 0;
    last = holdStart ? FRAME_CYC + 1 : FRAME_CYC + 2;
    applyStimulus(fb, 1'b1);
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      t = c - 1;
      expDout = 1'b0;
      if (t < SEND_CYC) begin
        b  = t / T_BIT;
        ph = t % T_BIT;
        expDout = (ph < (expBit(fb, b) ? T1H : T0H));
      end
      expBusy = (c <= FRAME_CYC);
      if (bus.dout !== expDout) begin
        if (doutErr == 0) firstErr = c;
        doutErr++;
      end
      if (bus.busy !== expBusy) busyErr++;
      if (bus.frame_done !== 1'b0) begin
        doneCount++;
        doneAt  = c;
        doneCyc = cyc;
      end
      if (t < SEND_CYC) begin
        if (ph == 0) highCnt = 0;
        if (bus.dout === 1'b1) highCnt++;
        if (ph == T_BIT - 1) begin
          decoded = (highCnt == T1H) ? 1'b1 : (highCnt == T0H) ? 1'b0 : 1'bx;
          if (decoded !== expBit(fb, b)) decErr++;
        end
      end
      if (c == 1 && !holdStart) bus.start = 1'b0;
      if (c == pulseAt) begin
        bus.framebuf = altFb;
        bus.start    = 1'b1;
      end else if (c == pulseAt + 1 && !holdStart) begin
        bus.start = 1'b0;
      end
    end
    if (doutErr != 0) $display("[TB] %s first dout difference at cycle %0d", tag, firstErr);
    checkOutput({tag, "_dout_cycles_wrong"}, doutErr, 0);
    checkOutput({tag, "_busy_cycles_wrong"}, busyErr, 0);
    checkOutput({tag, "_decoded_bits_wrong"}, decErr, 0);
    checkOutput({tag, "_frame_done_count"}, doneCount, 1);
    checkOutput({tag, "_frame_done_cycle"}, doneAt, FRAME_CYC);
  endtask

  initial begin
    logic [NB-1:0] fb;
    int            d1, d2, d3, base, bad;
    checks = 0;
    errors = 0;
    nrst   = 1'b0;
    applyStimulus('0, 1'b0);
    #1;
    checkOutput("reset_dout", bus.dout, 0);
    checkOutput("reset_busy", bus.busy, 0);
    checkOutput("reset_frame_done", bus.frame_done, 0);
    repeat (3) @(negedge clk);
    nrst = 1'b1;

    $display("[TB] idle with start low");
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (bus.dout !== 1'b0 || bus.busy !== 1'b0 || bus.frame_done !== 1'b0) bad++;
    end
    checkOutput("idle_quiet_violations", bad, 0);

    $display("[TB] all-zero frame");
    runFrame('0, "all_zero", -1, '0, 1'b0, d1);

    $display("[TB] bit order frame");
    fb = '0;
    fb[23:0] = 24'hFF0081;
    runFrame(fb, "bit_order", -1, '0, 1'b0, d1);

    $display("[TB] snapshot and start ignored mid-frame");
    runFrame(randFb(), "snapshot", 100, '1, 1'b0, d1);

    $display("[TB] start on frame_done cycle is dropped");
    runFrame(randFb(), "drop_on_done", FRAME_CYC, randFb(), 1'b0, d1);

    $display("[TB] back-to-back frames");
    base = cyc;
    runFrame(randFb(), "b2b_1", -1, '0, 1'b1, d1);
    runFrame(randFb(), "b2b_2", -1, '0, 1'b1, d2);
    runFrame(randFb(), "b2b_3", -1, '0, 1'b0, d3);
    checkOutput("b2b_done_1", d1 - base, 6360);
    checkOutput("b2b_done_2", d2 - base, 12721);
    checkOutput("b2b_done_3", d3 - base, 19082);

    $display("[TB] asynchronous reset during bit 50");
    applyStimulus(randFb(), 1'b1);
    for (int c = 1; c <= 50*T_BIT + 2; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
    end
    checkOutput("pre_reset_dout", bus.dout, 1);
    checkOutput("pre_reset_busy", bus.busy, 1);
    nrst = 1'b0;
    #1;
    checkOutput("async_reset_dout", bus.dout, 0);
    checkOutput("async_reset_busy", bus.busy, 0);
    checkOutput("async_reset_frame_done", bus.frame_done, 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_busy", bus.busy, 0);
    checkOutput("post_reset_dout", bus.dout, 0);
    runFrame(randFb(), "after_reset", -1, '0, 1'b0, d1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
